// File: rtl/cortex_lb_pkg.sv
// Shared types and constants for the cortex_s to local-bus bridge.
package cortex_lb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RD,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        rd;
      logic [17:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   localparam int          CMD_W          = 51;
   localparam logic [3:0]  INT_BLOCK_ID   = 4'hF;
   localparam logic [2:0]  REG_VERSION    = 3'd0;
   localparam logic [2:0]  REG_IRQ_STATUS = 3'd1;
   localparam logic [2:0]  REG_IRQ_MASK   = 3'd2;
   localparam logic [2:0]  REG_ERR        = 3'd3;
   localparam logic [2:0]  REG_TMO_CNT    = 3'd4;
   localparam logic [31:0] VERSION_VAL    = 32'h4C42_0001;
   localparam logic [31:0] TMO_DATA       = 32'hDEAD_BEEF;

endpackage

// File: rtl/cortex_lb_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module cortex_lb_cmd_fifo #(
   parameter int WIDTH = 51,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cortex_lb_bridge.sv
// Terminates the cortex_s Avalon-MM stream into a FIFO and replays it onto the local bus.
// Optional read-response timeout is enabled by defining CORTEX_LB_TIMEOUT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a command; pops the FIFO head when present
// ST_ISSUE   | drives the local-bus strobe or performs internal access
// ST_WAIT_RD | waiting for lb_rd_valid (or timeout when enabled)
// ST_RESP    | returns read data on readdatavalid for read commands
module cortex_lb_bridge
   import cortex_lb_pkg::*;
#(
   parameter int CMD_FIFO_DEPTH = 8,
   parameter int IRQ_W          = 8,
   parameter int RD_TIMEOUT     = 1023
) (
   input  logic             clk_100_clk,
   input  logic             reset_100_reset_n,
   input  logic [17:0]      cortex_s_address,
   input  logic             cortex_s_read,
   input  logic             cortex_s_write,
   input  logic [31:0]      cortex_s_writedata,
   output logic [31:0]      cortex_s_readdata,
   output logic             cortex_s_readdatavalid,
   output logic             cortex_irq_irq,
   output logic             lb_wr_en,
   output logic             lb_rd_en,
   output logic [17:0]      lb_addr,
   output logic [31:0]      lb_wr_data,
   input  logic             lb_rd_valid,
   input  logic [31:0]      lb_rd_data,
   input  logic [IRQ_W-1:0] irq_src
);

   state_t           state;
   state_t           state_nxt;
   cmd_t             push_cmd;
   cmd_t             head_cmd;
   cmd_t             cmd;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             ovf_set;
   logic             is_int;
   logic             int_wr;
   logic [2:0]       off;
   logic             rd_valid_q;
   logic [31:0]      rd_data_q;
   logic [31:0]      resp_data;
   logic [31:0]      reg_rdata;
   logic [IRQ_W-1:0] irq_status;
   logic [IRQ_W-1:0] irq_mask;
   logic [IRQ_W-1:0] status_clr;
   logic             err_wr;
   logic             err_ovf;
`ifdef CORTEX_LB_TIMEOUT_EN
   logic             err_tmo;
   logic [15:0]      tmo_cnt;
   logic [15:0]      tmo_left;
   logic             tmo_hit;
`endif

   // A simultaneous read+write keeps the write and drops the read.
   assign push     = cortex_s_read | cortex_s_write;
   assign push_cmd = {cortex_s_read & ~cortex_s_write, cortex_s_address, cortex_s_writedata};
   assign ovf_set  = push & fifo_full & ~pop;

   cortex_lb_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk_100_clk),
      .rst_n     (reset_100_reset_n),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign is_int            = (cmd.addr[17:14] == INT_BLOCK_ID);
   assign off               = cmd.addr[2:0];
   assign int_wr            = (state == ST_ISSUE) && is_int && !cmd.rd;
   assign err_wr            = int_wr && (off == REG_ERR);
   assign status_clr        = (int_wr && off == REG_IRQ_STATUS) ? cmd.wdata[IRQ_W-1:0] : '0;
   assign lb_addr           = cmd.addr;
   assign lb_wr_data        = cmd.wdata;
   assign cortex_s_readdata = resp_data;

   always_comb begin
      state_nxt              = state;
      pop                    = 1'b0;
      lb_wr_en               = 1'b0;
      lb_rd_en               = 1'b0;
      cortex_s_readdatavalid = 1'b0;
`ifdef CORTEX_LB_TIMEOUT_EN
      tmo_hit                = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (is_int) begin
               state_nxt = ST_RESP;
            end else if (cmd.rd) begin
               lb_rd_en  = 1'b1;
               state_nxt = ST_WAIT_RD;
            end else begin
               lb_wr_en  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_RD: begin
            if (rd_valid_q) begin
               state_nxt = ST_RESP;
            end
`ifdef CORTEX_LB_TIMEOUT_EN
            else if (tmo_left == 16'd0) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            cortex_s_readdatavalid = cmd.rd;
            state_nxt              = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Local-bus response is registered, which gives the two-cycle valid-to-readdatavalid latency.
   always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
      if (!reset_100_reset_n) begin
         state      <= ST_IDLE;
         cmd        <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         resp_data  <= '0;
      end else begin
         state      <= state_nxt;
         rd_valid_q <= lb_rd_valid && (state == ST_WAIT_RD);
         rd_data_q  <= lb_rd_data;
         if (pop) cmd <= head_cmd;
         if (state == ST_ISSUE && is_int) resp_data <= reg_rdata;
         else if (state == ST_WAIT_RD && rd_valid_q) resp_data <= rd_data_q;
`ifdef CORTEX_LB_TIMEOUT_EN
         else if (tmo_hit) resp_data <= TMO_DATA;
`endif
      end
   end

   always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
      if (!reset_100_reset_n) begin
         irq_status     <= '0;
         irq_mask       <= '0;
         err_ovf        <= 1'b0;
         cortex_irq_irq <= 1'b0;
      end else begin
         irq_status     <= (irq_status & ~status_clr) | irq_src;
         err_ovf        <= (err_ovf & ~(err_wr & cmd.wdata[0])) | ovf_set;
         cortex_irq_irq <= |(irq_status & irq_mask);
         if (int_wr && off == REG_IRQ_MASK) irq_mask <= cmd.wdata[IRQ_W-1:0];
      end
   end

`ifdef CORTEX_LB_TIMEOUT_EN
   always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
      if (!reset_100_reset_n) begin
         err_tmo  <= 1'b0;
         tmo_cnt  <= '0;
         tmo_left <= '0;
      end else begin
         err_tmo <= (err_tmo & ~(err_wr & cmd.wdata[1])) | tmo_hit;
         if (tmo_hit && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
         if (state == ST_ISSUE) tmo_left <= 16'(RD_TIMEOUT - 1);
         else if (state == ST_WAIT_RD && tmo_left != 16'd0) tmo_left <= tmo_left - 16'd1;
      end
   end
`endif

   always_comb begin
      reg_rdata = '0;
      case (off)
         REG_VERSION:    reg_rdata = VERSION_VAL;
         REG_IRQ_STATUS: reg_rdata[IRQ_W-1:0] = irq_status;
         REG_IRQ_MASK:   reg_rdata[IRQ_W-1:0] = irq_mask;
         REG_ERR: begin
            reg_rdata[0] = err_ovf;
`ifdef CORTEX_LB_TIMEOUT_EN
            reg_rdata[1] = err_tmo;
`endif
         end
         REG_TMO_CNT: begin
`ifdef CORTEX_LB_TIMEOUT_EN
            reg_rdata[15:0] = tmo_cnt;
`endif
         end
         default: reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cortex_lb_bridge.sv
// Self-checking bench for cortex_lb_bridge with a memory-backed local-bus responder.
module tb_cortex_lb_bridge;

   localparam int          DEPTH      = 8;
   localparam int          IRQ_W      = 8;
   localparam int          RD_TIMEOUT = 1023;
   localparam logic [17:0] INT_BASE   = 18'h3C000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [17:0]      cortex_s_address = '0;
   logic             cortex_s_read = 1'b0;
   logic             cortex_s_write = 1'b0;
   logic [31:0]      cortex_s_writedata = '0;
   logic [31:0]      cortex_s_readdata;
   logic             cortex_s_readdatavalid;
   logic             cortex_irq_irq;
   logic             lb_wr_en;
   logic             lb_rd_en;
   logic [17:0]      lb_addr;
   logic [31:0]      lb_wr_data;
   logic             lb_rd_valid;
   logic [31:0]      lb_rd_data;
   logic [IRQ_W-1:0] irq_src = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] lbmem [logic [17:0]];
   logic [49:0] wr_q[$];
   logic [31:0] rdv_q[$];
   int          rdv_cyc_q[$];
   int          rv_cyc_q[$];
   int          rden_cyc_q[$];
   logic [17:0] rd_addr_q[$];
   int          lat_q[$];
   bit          no_resp = 1'b0;

   cortex_lb_bridge #(
      .CMD_FIFO_DEPTH (DEPTH),
      .IRQ_W          (IRQ_W),
      .RD_TIMEOUT     (RD_TIMEOUT)
   ) dut (
      .clk_100_clk            (clk),
      .reset_100_reset_n      (rst_n),
      .cortex_s_address       (cortex_s_address),
      .cortex_s_read          (cortex_s_read),
      .cortex_s_write         (cortex_s_write),
      .cortex_s_writedata     (cortex_s_writedata),
      .cortex_s_readdata      (cortex_s_readdata),
      .cortex_s_readdatavalid (cortex_s_readdatavalid),
      .cortex_irq_irq         (cortex_irq_irq),
      .lb_wr_en               (lb_wr_en),
      .lb_rd_en               (lb_rd_en),
      .lb_addr                (lb_addr),
      .lb_wr_data             (lb_wr_data),
      .lb_rd_valid            (lb_rd_valid),
      .lb_rd_data             (lb_rd_data),
      .irq_src                (irq_src)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Local-bus memory model and output monitor, all sampled on the falling edge.
   initial begin : lb_model
      bit          pend;
      int          due;
      int          lat;
      logic [31:0] pend_data;
      pend = 1'b0; due = 0; pend_data = '0;
      lb_rd_valid = 1'b0;
      lb_rd_data  = '0;
      forever begin
         @(negedge clk);
         lb_rd_valid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (lb_wr_en === 1'b1) begin
               wr_q.push_back({lb_addr, lb_wr_data});
               lbmem[lb_addr] = lb_wr_data;
            end
            if (cortex_s_readdatavalid === 1'b1) begin
               rdv_q.push_back(cortex_s_readdata);
               rdv_cyc_q.push_back(cyc);
            end
            if (pend && cyc == due) begin
               lb_rd_valid = 1'b1;
               lb_rd_data  = pend_data;
               pend        = 1'b0;
               rv_cyc_q.push_back(cyc);
            end
            if (lb_rd_en === 1'b1) begin
               rd_addr_q.push_back(lb_addr);
               rden_cyc_q.push_back(cyc);
               if (!no_resp) begin
                  lat       = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
                  pend      = 1'b1;
                  due       = cyc + lat;
                  pend_data = lbmem.exists(lb_addr) ? lbmem[lb_addr] : 32'(lb_addr) + 32'h100;
               end
            end
         end
      end
   end

   task automatic clear_logs();
      wr_q.delete(); rdv_q.delete(); rdv_cyc_q.delete(); rv_cyc_q.delete();
      rden_cyc_q.delete(); rd_addr_q.delete(); lat_q.delete();
   endtask

   task automatic push(input logic rd, input logic wr, input logic [17:0] a, input logic [31:0] d);
      @(negedge clk);
      cortex_s_read      = rd;
      cortex_s_write     = wr;
      cortex_s_address   = a;
      cortex_s_writedata = d;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      cortex_s_read  = 1'b0;
      cortex_s_write = 1'b0;
   endtask

   task automatic wait_rdv(input int budget, output bit ok, output logic [31:0] d, output int c);
      int i;
      ok = 1'b0; d = 'x; c = -1; i = 0;
      while (!ok && i < budget) begin
         @(posedge clk);
         if (rdv_q.size() > 0) begin
            d  = rdv_q.pop_front();
            c  = rdv_cyc_q.pop_front();
            ok = 1'b1;
         end
         i++;
      end
   endtask

   task automatic reg_read(input logic [2:0] off, output logic [31:0] d, output int lat);
      bit ok;
      int pc;
      int c;
      push(1'b1, 1'b0, INT_BASE | 18'(off), 32'h0);
      pc = cyc;
      bus_idle();
      wait_rdv(40, ok, d, c);
      lat = c - pc;
      if (!ok) begin
         miscompares++; vectors++;
         $display("FAIL reg_read_timeout off=%0d: got no readdatavalid, exp one within 40 cycles", off);
      end
   endtask

   task automatic reg_write(input logic [2:0] off, input logic [31:0] d);
      push(1'b0, 1'b1, INT_BASE | 18'(off), d);
      bus_idle();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int          lat;
      logic [31:0] exp_regs [8];
      exp_regs = '{32'h4C42_0001, 0, 0, 0, 0, 0, 0, 0};
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({lb_wr_en, lb_rd_en, lb_addr, lb_wr_data, cortex_s_readdata, cortex_s_readdatavalid, cortex_irq_irq} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got wr=%b rd=%b addr=%h wd=%h rdata=%h rdv=%b irq=%b, exp all 0",
                  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data, cortex_s_readdata, cortex_s_readdatavalid, cortex_irq_irq);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         reg_read(3'(i), d, lat);
         vectors++;
         if (d !== exp_regs[i]) begin
            miscompares++;
            $display("FAIL reset_reg[%0d]: got %h exp %h", i, d, exp_regs[i]);
         end
      end
      reg_read(3'd0, d, lat);
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL internal_read_latency: got %0d exp 3", lat);
      end
   endtask

   task automatic test_write_read();
      bit          ok;
      logic [31:0] d;
      int          c;
      int          rv;
      clear_logs();
      push(1'b0, 1'b1, 18'h00010, 32'h1234_5678);
      bus_idle();
      repeat (6) @(negedge clk);
      vectors++;
      if (wr_q.size() != 1 || wr_q[0] !== {18'h00010, 32'h1234_5678}) begin
         miscompares++;
         $display("FAIL wr_single: got %0d writes first=%h exp 1 write %h", wr_q.size(),
                  (wr_q.size() > 0) ? wr_q[0] : 50'h0, {18'h00010, 32'h1234_5678});
      end
      lat_q.push_back(3);
      push(1'b1, 1'b0, 18'h00010, 32'h0);
      bus_idle();
      wait_rdv(40, ok, d, c);
      rv = (rv_cyc_q.size() > 0) ? rv_cyc_q.pop_front() : -100;
      vectors++;
      if (!ok || d !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL rd_after_wr: got ok=%b data=%h exp data 12345678", ok, d);
      end
      vectors++;
      if (c - rv !== 2) begin
         miscompares++;
         $display("FAIL rd_resp_latency: got %0d exp 2", c - rv);
      end
      // Read and write together: only the write survives.
      clear_logs();
      push(1'b1, 1'b1, 18'h00020, 32'hCAFE_0001);
      bus_idle();
      repeat (20) @(negedge clk);
      vectors++;
      if (wr_q.size() != 1 || rd_addr_q.size() != 0 || rdv_q.size() != 0) begin
         miscompares++;
         $display("FAIL rd_wr_collision: got writes=%0d reads=%0d rdv=%0d exp 1 0 0",
                  wr_q.size(), rd_addr_q.size(), rdv_q.size());
      end
   endtask

   task automatic test_burst_reads();
      bit          ok;
      logic [31:0] d;
      int          c;
      int          rv;
      clear_logs();
      lat_q = '{5, 1, 3, 2};
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 18'(i), 32'h0);
      bus_idle();
      for (int i = 0; i < 4; i++) begin
         wait_rdv(60, ok, d, c);
         rv = (rv_cyc_q.size() > 0) ? rv_cyc_q.pop_front() : -100;
         vectors++;
         if (!ok || d !== 32'h100 + 32'(i) || c - rv != 2) begin
            miscompares++;
            $display("FAIL burst_rd[%0d]: got ok=%b data=%h lat=%0d exp data %h lat 2",
                     i, ok, d, c - rv, 32'h100 + 32'(i));
         end
      end
   endtask

   task automatic test_overflow_burst(input int n, input logic [17:0] base);
      logic [49:0] exp_wr[$];
      logic [31:0] dat [32];
      logic [31:0] d;
      int          occ;
      int          lat;
      bit          p;
      bit          acc;
      bit          dropped;
      clear_logs();
      occ = 0; dropped = 1'b0;
      for (int t = 0; t < n; t++) dat[t] = $urandom;
      // Writes drain one per two cycles starting the cycle after the first push.
      for (int t = 0; t < n; t++) begin
         p   = (t % 2 == 1) && (occ > 0);
         acc = (occ < DEPTH) || p;
         if (acc) exp_wr.push_back({base + 18'(t), dat[t]});
         else     dropped = 1'b1;
         occ = occ + (acc ? 1 : 0) - (p ? 1 : 0);
      end
      for (int t = 0; t < n; t++) push(1'b0, 1'b1, base + 18'(t), dat[t]);
      bus_idle();
      repeat (60) @(negedge clk);
      vectors++;
      if (wr_q.size() != exp_wr.size()) begin
         miscompares++;
         $display("FAIL ovf_write_count n=%0d: got %0d exp %0d", n, wr_q.size(), exp_wr.size());
      end else begin
         for (int i = 0; i < exp_wr.size(); i++) begin
            vectors++;
            if (wr_q[i] !== exp_wr[i]) begin
               miscompares++;
               $display("FAIL ovf_write[%0d]: got %h exp %h", i, wr_q[i], exp_wr[i]);
            end
         end
      end
      reg_read(3'd3, d, lat);
      vectors++;
      if (d !== {31'd0, dropped}) begin
         miscompares++;
         $display("FAIL err_ovf n=%0d: got %h exp %h", n, d, {31'd0, dropped});
      end
      reg_write(3'd3, 32'h1);
      reg_read(3'd3, d, lat);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL err_ovf_clear: got %h exp 0", d);
      end
   endtask

   task automatic test_irq();
      logic [31:0]      d;
      int               lat;
      logic [IRQ_W-1:0] m;
      logic [IRQ_W-1:0] s;
      bit               seen;
      reg_write(3'd2, 32'h04);
      @(negedge clk); irq_src = 8'h04;
      @(negedge clk); irq_src = '0;
      vectors++;
      if (cortex_irq_irq !== 1'b0) begin
         miscompares++;
         $display("FAIL irq_early: got %b exp 0 one cycle after source", cortex_irq_irq);
      end
      @(negedge clk);
      vectors++;
      if (cortex_irq_irq !== 1'b1) begin
         miscompares++;
         $display("FAIL irq_assert: got %b exp 1 two cycles after source", cortex_irq_irq);
      end
      reg_write(3'd1, 32'h04);
      vectors++;
      if (cortex_irq_irq !== 1'b0) begin
         miscompares++;
         $display("FAIL irq_clear: got %b exp 0", cortex_irq_irq);
      end
      @(negedge clk); irq_src = 8'h08;
      @(negedge clk); irq_src = '0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (cortex_irq_irq !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL irq_masked_src: got irq high exp low");
      end
      reg_read(3'd1, d, lat);
      vectors++;
      if (d !== 32'h08) begin
         miscompares++;
         $display("FAIL irq_status_masked: got %h exp 00000008", d);
      end
      reg_write(3'd1, 32'h08);
      for (int k = 0; k < 4; k++) begin
         m = IRQ_W'($urandom);
         s = IRQ_W'($urandom_range(1, 255));
         reg_write(3'd2, 32'(m));
         @(negedge clk); irq_src = s;
         @(negedge clk); irq_src = '0;
         @(negedge clk);
         vectors++;
         if (cortex_irq_irq !== ((s & m) != 0)) begin
            miscompares++;
            $display("FAIL irq_rand[%0d] m=%h s=%h: got %b exp %b", k, m, s, cortex_irq_irq, (s & m) != 0);
         end
         reg_read(3'd1, d, lat);
         vectors++;
         if (d !== 32'(s)) begin
            miscompares++;
            $display("FAIL irq_status_rand[%0d]: got %h exp %h", k, d, 32'(s));
         end
         reg_write(3'd1, 32'(s));
      end
      reg_write(3'd2, 32'h0);
   endtask

   task automatic test_random_traffic();
      logic [31:0] expmem [logic [17:0]];
      logic [31:0] exp_rd[$];
      logic [49:0] exp_wr[$];
      bit          ok;
      logic [31:0] d;
      logic [31:0] wd;
      logic [17:0] a;
      int          c;
      int          n;
      for (int r = 0; r < 5; r++) begin
         clear_logs();
         exp_rd.delete(); exp_wr.delete();
         n = $urandom_range(4, 6);
         for (int i = 0; i < n; i++) begin
            a  = 18'h40 + 18'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               exp_rd.push_back(expmem.exists(a) ? expmem[a] : 32'(a) + 32'h100);
               lat_q.push_back($urandom_range(1, 5));
               push(1'b1, 1'b0, a, 32'h0);
            end else begin
               expmem[a] = wd;
               exp_wr.push_back({a, wd});
               push(1'b0, 1'b1, a, wd);
            end
            repeat ($urandom_range(0, 2)) bus_idle();
         end
         bus_idle();
         for (int i = 0; i < exp_rd.size(); i++) begin
            wait_rdv(80, ok, d, c);
            vectors++;
            if (!ok || d !== exp_rd[i]) begin
               miscompares++;
               $display("FAIL rand_rd r=%0d i=%0d: got ok=%b %h exp %h", r, i, ok, d, exp_rd[i]);
            end
         end
         repeat (10) @(negedge clk);
         vectors++;
         if (wr_q != exp_wr) begin
            miscompares++;
            $display("FAIL rand_wr r=%0d: got %0d writes exp %0d (contents differ)", r, wr_q.size(), exp_wr.size());
         end
      end
   endtask

   task automatic test_timeout();
      bit          ok;
      logic [31:0] d;
      int          c;
      int          re;
      clear_logs();
      no_resp = 1'b1;
      push(1'b1, 1'b0, 18'h00050, 32'h0);
      bus_idle();
`ifdef CORTEX_LB_TIMEOUT_EN
      begin
         int lat;
         wait_rdv(RD_TIMEOUT + 40, ok, d, c);
         re = (rden_cyc_q.size() > 0) ? rden_cyc_q[0] : -100000;
         vectors++;
         if (!ok || d !== 32'hDEAD_BEEF || c - re < RD_TIMEOUT || c - re > RD_TIMEOUT + 2) begin
            miscompares++;
            $display("FAIL tmo_resp: got ok=%b data=%h after %0d exp DEADBEEF after about %0d",
                     ok, d, c - re, RD_TIMEOUT);
         end
         no_resp = 1'b0;
         reg_read(3'd3, d, lat);
         vectors++;
         if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL tmo_err: got %h exp 00000002", d);
         end
         reg_read(3'd4, d, lat);
         vectors++;
         if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL tmo_cnt: got %h exp 00000001", d);
         end
         reg_write(3'd3, 32'h2);
         reg_read(3'd3, d, lat);
         vectors++;
         if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL tmo_err_clear: got %h exp 0", d);
         end
      end
`else
      ok = 1'b0; c = 0; re = 0; d = '0;
      repeat (2 * RD_TIMEOUT) @(negedge clk);
      vectors++;
      if (rdv_q.size() != 0 || rd_addr_q.size() != 1) begin
         miscompares++;
         $display("FAIL no_tmo: got rdv=%0d rd_en=%0d exp 0 and 1", rdv_q.size(), rd_addr_q.size());
      end
`endif
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d;
      int          lat;
      no_resp = 1'b1;
`ifdef CORTEX_LB_TIMEOUT_EN
      push(1'b1, 1'b0, 18'h00060, 32'h0);
      bus_idle();
      repeat (10) @(negedge clk);
`endif
      clear_logs();
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 18'h70 + 18'(i), $urandom);
      bus_idle();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({lb_wr_en, lb_rd_en, lb_addr, lb_wr_data, cortex_s_readdata, cortex_s_readdatavalid, cortex_irq_irq} !== '0) begin
         miscompares++;
         $display("FAIL reset_async_outputs: got wr=%b rd=%b addr=%h rdata=%h rdv=%b exp all 0",
                  lb_wr_en, lb_rd_en, lb_addr, cortex_s_readdata, cortex_s_readdatavalid);
      end
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      no_resp = 1'b0;
      repeat (30) @(negedge clk);
      vectors++;
      if (wr_q.size() != 0 || rdv_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_flush: got writes=%0d rdv=%0d exp 0 0", wr_q.size(), rdv_q.size());
      end
      reg_read(3'd0, d, lat);
      vectors++;
      if (d !== 32'h4C42_0001) begin
         miscompares++;
         $display("FAIL post_reset_version: got %h exp 4c420001", d);
      end
      reg_read(3'd4, d, lat);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL post_reset_tmo_cnt: got %h exp 0", d);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_burst_reads();
      test_overflow_burst(10, 18'h00100);
      test_overflow_burst(24, 18'h00200);
      test_irq();
      test_random_traffic();
      test_timeout();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
